// File: rtl/tabla_axi_ctrl_pkg.sv
// rtl/tabla_axi_ctrl_pkg.sv - register map, response code and FSM encodings for the Tabla AXI-Lite control slave
package tabla_axi_ctrl_pkg;

  localparam int REG_IDX_W = 4;

  localparam logic [REG_IDX_W-1:0] REG_CTRL      = 4'd0;
  localparam logic [REG_IDX_W-1:0] REG_TX_DONE   = 4'd1;
  localparam logic [REG_IDX_W-1:0] REG_RD_DONE   = 4'd2;
  localparam logic [REG_IDX_W-1:0] REG_WR_DONE   = 4'd3;
  localparam logic [REG_IDX_W-1:0] REG_TOTAL     = 4'd4;
  localparam logic [REG_IDX_W-1:0] REG_RD_CYC    = 4'd5;
  localparam logic [REG_IDX_W-1:0] REG_PR_CYC    = 4'd6;
  localparam logic [REG_IDX_W-1:0] REG_WR_CYC    = 4'd7;
  localparam logic [REG_IDX_W-1:0] REG_PROC_DONE = 4'd8;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

endpackage

// File: rtl/tabla_axi_ctrl_slave.sv
// rtl/tabla_axi_ctrl_slave.sv - AXI4-Lite control/status register file for the Tabla accelerator
module tabla_axi_ctrl_slave
  import tabla_axi_ctrl_pkg::*;
#(
  parameter int PERF_CNTR_WIDTH = 32,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXIS_ADDR_WIDTH = 6
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESET,
  output logic                         tx_req,
  output logic [AXIS_DATA_WIDTH-1:0]   ctrl_reg,
  input  logic                         tx_done,
  input  logic                         rd_done,
  input  logic                         wr_done,
  input  logic                         processing_done,
  input  logic [PERF_CNTR_WIDTH-1:0]   total_cycles,
  input  logic [PERF_CNTR_WIDTH-1:0]   rd_cycles,
  input  logic [PERF_CNTR_WIDTH-1:0]   pr_cycles,
  input  logic [PERF_CNTR_WIDTH-1:0]   wr_cycles,
  input  logic [AXIS_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [AXIS_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXIS_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [AXIS_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [AXIS_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY
);

  logic                         clk;
  logic                         rst;
  logic [0:0]                   w_state;
  logic [0:0]                   r_state;
  logic                         wr_accept;
  logic                         rd_accept;
  logic [AXIS_ADDR_WIDTH-3:0]   wr_idx;
  logic [AXIS_ADDR_WIDTH-3:0]   rd_idx;
  logic [AXIS_DATA_WIDTH-1:0]   rd_mux;
  logic                         unused_ok;

  assign clk    = S_AXI_ACLK;
  assign rst    = S_AXI_ARESET;
  assign wr_idx = S_AXI_AWADDR[AXIS_ADDR_WIDTH-1:2];
  assign rd_idx = S_AXI_ARADDR[AXIS_ADDR_WIDTH-1:2];

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Ready is combinational so the handshake lands in the same cycle both valids are seen;
  // gating with rst keeps it low throughout reset.
  assign wr_accept = !rst && (w_state == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_accept = !rst && (r_state == R_IDLE) && S_AXI_ARVALID;

  assign S_AXI_AWREADY = wr_accept;
  assign S_AXI_WREADY  = wr_accept;
  assign S_AXI_ARREADY = rd_accept;
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RRESP   = RESP_OKAY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state  <= W_IDLE;
      ctrl_reg <= '0;
      tx_req   <= 1'b0;
    end else begin
      tx_req <= wr_accept && (wr_idx == REG_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
      case (w_state)
        W_IDLE: begin
          if (wr_accept) begin
            w_state <= W_RESP;
            if (wr_idx == REG_CTRL) begin
              for (int b = 0; b < AXIS_DATA_WIDTH/8; b++) begin
                if (S_AXI_WSTRB[b]) ctrl_reg[b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
              end
            end
          end
        end
        default: begin
          if (S_AXI_BREADY) w_state <= W_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      REG_CTRL:      rd_mux = ctrl_reg;
      REG_TX_DONE:   rd_mux = AXIS_DATA_WIDTH'(tx_done);
      REG_RD_DONE:   rd_mux = AXIS_DATA_WIDTH'(rd_done);
      REG_WR_DONE:   rd_mux = AXIS_DATA_WIDTH'(wr_done);
      REG_TOTAL:     rd_mux = AXIS_DATA_WIDTH'(total_cycles);
      REG_RD_CYC:    rd_mux = AXIS_DATA_WIDTH'(rd_cycles);
      REG_PR_CYC:    rd_mux = AXIS_DATA_WIDTH'(pr_cycles);
      REG_WR_CYC:    rd_mux = AXIS_DATA_WIDTH'(wr_cycles);
      REG_PROC_DONE: rd_mux = AXIS_DATA_WIDTH'(processing_done);
      default:       rd_mux = '0;
    endcase
  end

  // RDATA samples ctrl_reg before any same-edge write lands, so a colliding read sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= R_IDLE;
      S_AXI_RDATA <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (rd_accept) begin
            r_state     <= R_DATA;
            S_AXI_RDATA <= rd_mux;
          end
        end
        default: begin
          if (S_AXI_RREADY) r_state <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tabla_axi_ctrl_slave.sv
// tb/tb_tabla_axi_ctrl_slave.sv - scoreboard bench for tabla_axi_ctrl_slave
module tb_tabla_axi_ctrl_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_req;
  logic [31:0] ctrl_reg;
  logic        tx_done, rd_done, wr_done, processing_done;
  logic [31:0] total_cycles, rd_cycles, pr_cycles, wr_cycles;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] rq[$];
  logic [1:0]  bq[$];

  always #5 clk = ~clk;

  tabla_axi_ctrl_slave #(.PERF_CNTR_WIDTH(32), .AXIS_DATA_WIDTH(32), .AXIS_ADDR_WIDTH(6)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .tx_req(tx_req), .ctrl_reg(ctrl_reg),
    .tx_done(tx_done), .rd_done(rd_done), .wr_done(wr_done), .processing_done(processing_done),
    .total_cycles(total_cycles), .rd_cycles(rd_cycles), .pr_cycles(pr_cycles), .wr_cycles(wr_cycles),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation every time a response handshake completes.
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) check("b_unexpected", 32'd1, 32'd0);
        else check("bresp", {30'd0, bresp}, {30'd0, bq.pop_front()});
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) check("r_unexpected", 32'd1, 32'd0);
        else begin
          check("rdata", rdata, rq.pop_front());
          check("rresp", {30'd0, rresp}, 32'd0);
        end
      end
    end
  end

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input logic exp_tx);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    bq.push_back(2'b00);
    @(negedge clk);
    while (!awready && n < 20) begin n++; @(negedge clk); end
    check("aw_ready", {31'd0, awready}, 32'd1);
    check("w_ready_same_cycle", {31'd0, wready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("b_valid", {31'd0, bvalid}, 32'd1);
    check("tx_req", {31'd0, tx_req}, {31'd0, exp_tx});
    @(posedge clk); #1;
    if (bready) begin
      check("b_done", {31'd0, bvalid}, 32'd0);
      check("tx_req_end", {31'd0, tx_req}, 32'd0);
    end
  endtask

  task automatic axi_read(input logic [5:0] a, input logic [31:0] exp);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    rq.push_back(exp);
    @(negedge clk);
    while (!arready && n < 20) begin n++; @(negedge clk); end
    check("ar_ready", {31'd0, arready}, 32'd1);
    check("r_valid_early", {31'd0, rvalid}, 32'd0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (rready) begin
      @(negedge clk);
      check("r_valid", {31'd0, rvalid}, 32'd1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    tx_done = 1'b1; rd_done = 1'b0; wr_done = 1'b1; processing_done = 1'b1;
    total_cycles = 32'h12345678; rd_cycles = 32'h0000_00A5; pr_cycles = 32'hCAFE_0001; wr_cycles = 32'h8000_0000;

    repeat (2) @(negedge clk);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_tx_req", {31'd0, tx_req}, 32'd0);
    check("rst_ctrl", ctrl_reg, 32'd0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    axi_write(6'h00, 32'hDEADBEEF, 4'hF, 1'b1);
    check("ctrl_deadbeef", ctrl_reg, 32'hDEADBEEF);
    axi_read(6'h00, 32'hDEADBEEF);

    axi_write(6'h00, 32'h00000001, 4'hF, 1'b1);
    axi_write(6'h00, 32'h00000002, 4'hF, 1'b0);
    axi_write(6'h00, 32'h00000001, 4'h2, 1'b0);

    axi_read(6'h04, 32'h1);
    axi_read(6'h08, 32'h0);
    axi_read(6'h0C, 32'h1);
    axi_read(6'h10, 32'h12345678);
    axi_read(6'h14, 32'h000000A5);
    axi_read(6'h18, 32'hCAFE0001);
    axi_read(6'h1C, 32'h80000000);
    axi_read(6'h20, 32'h1);
    axi_read(6'h3C, 32'h0);

    axi_write(6'h00, 32'h00000000, 4'hF, 1'b0);
    axi_write(6'h00, 32'hFFFFFFFF, 4'b0010, 1'b0);
    check("ctrl_strobe", ctrl_reg, 32'h0000FF00);
    axi_read(6'h00, 32'h0000FF00);
    axi_write(6'h10, 32'h00000005, 4'hF, 1'b0);
    axi_read(6'h10, 32'h12345678);
    axi_write(6'h24, 32'hFFFFFFFF, 4'hF, 1'b0);
    check("ctrl_unmapped_wr", ctrl_reg, 32'h0000FF00);

    // Response back-pressure blocks the next write.
    bready = 1'b0;
    axi_write(6'h00, 32'h00000100, 4'hF, 1'b0);
    awaddr = 6'h00; wdata = 32'h00000200; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    bq.push_back(2'b00);
    repeat (5) begin
      @(negedge clk);
      check("blk_awready", {31'd0, awready}, 32'd0);
      check("blk_wready", {31'd0, wready}, 32'd0);
      check("blk_bvalid", {31'd0, bvalid}, 32'd1);
    end
    @(posedge clk); #1 bready = 1'b1;
    @(negedge clk);
    check("blk_awready_resp", {31'd0, awready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("unblk_awready", {31'd0, awready}, 32'd1);
    check("unblk_wready", {31'd0, wready}, 32'd1);
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("unblk_bvalid", {31'd0, bvalid}, 32'd1);
    @(posedge clk); #1;
    check("ctrl_after_blk", ctrl_reg, 32'h00000200);

    // Read data back-pressure holds RVALID/RDATA.
    rready = 1'b0;
    axi_read(6'h00, 32'h00000200);
    repeat (10) begin
      @(negedge clk);
      check("hold_rvalid", {31'd0, rvalid}, 32'd1);
      check("hold_rdata", rdata, 32'h00000200);
    end
    @(posedge clk); #1 rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;

    // Colliding read/write of CTRL, then reset while responses are pending.
    rready = 1'b0; bready = 1'b0;
    araddr = 6'h00; arvalid = 1'b1;
    awaddr = 6'h00; wdata = 32'h00000001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check("coll_arready", {31'd0, arready}, 32'd1);
    check("coll_awready", {31'd0, awready}, 32'd1);
    @(posedge clk); #2;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("coll_rdata_old", rdata, 32'h00000200);
    check("coll_ctrl_new", ctrl_reg, 32'h00000001);
    check("coll_tx_req", {31'd0, tx_req}, 32'd1);
    check("coll_rvalid", {31'd0, rvalid}, 32'd1);
    check("coll_bvalid", {31'd0, bvalid}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_rvalid", {31'd0, rvalid}, 32'd0);
    check("arst_bvalid", {31'd0, bvalid}, 32'd0);
    check("arst_tx_req", {31'd0, tx_req}, 32'd0);
    check("arst_ctrl", ctrl_reg, 32'd0);
    check("arst_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; rready = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    axi_read(6'h00, 32'h0);
    axi_read(6'h10, 32'h12345678);
    axi_write(6'h00, 32'h00000002, 4'hF, 1'b0);
    axi_read(6'h00, 32'h00000002);

    for (int i = 0; i < 20 && (rq.size() != 0 || bq.size() != 0); i++) @(posedge clk);
    check("rq_drained", rq.size(), 32'd0);
    check("bq_drained", bq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
